// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB stage: writeback source select, load funct3 codes, FSM states.
package mem_wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_RSVD = 2'd3;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_DRAIN     = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of a word-aligned
// response, sign/zero-extends it, and flags misaligned or undefined load types.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      LD_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      LD_LH: begin
        data  = {{(XLEN-16){half_sel[15]}}, half_sel};
        fault = addr[0];
      end
      LD_LHU: begin
        data  = {{(XLEN-16){1'b0}}, half_sel};
        fault = addr[0];
      end
      LD_LW: begin
        data  = rdata;
        fault = (addr != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: captures retiring instructions, waits for load responses, and drives the
// registered WriteRegister/WriteData/RegWrite triple plus a load-fault pulse.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_pc_plus4,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [REG_AW-1:0] WriteRegister,
  output logic [XLEN-1:0]   WriteData,
  output logic              RegWrite,
  output logic              misalign_err
);

  state_t state, next_state;

  logic [REG_AW-1:0] cap_rd;
  logic              cap_reg_write;
  logic [1:0]        cap_wb_sel;
  logic [2:0]        cap_funct3;
  logic [XLEN-1:0]   cap_alu;
  logic [XLEN-1:0]   cap_pc;

  logic              accept;
  logic              commit;
  logic [REG_AW-1:0] c_rd;
  logic              c_reg_write;
  logic [1:0]        c_wb_sel;
  logic [2:0]        c_funct3;
  logic [XLEN-1:0]   c_alu;
  logic [XLEN-1:0]   c_pc;
  logic [XLEN-1:0]   la_data;
  logic              la_fault;
  logic              c_fault;
  logic              c_write;
  logic [XLEN-1:0]   wb_data;

  assign in_ready = (state == ST_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (accept && in_wb_sel == WB_SEL_LOAD) next_state = ST_WAIT_LOAD;
      ST_WAIT_LOAD: if (dmem_rvalid) next_state = ST_IDLE;
                    else if (flush)  next_state = ST_DRAIN;
      ST_DRAIN:     if (dmem_rvalid) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Non-loads commit straight from the inputs; loads commit from the captured fields.
  always_comb begin
    commit      = 1'b0;
    c_rd        = cap_rd;
    c_reg_write = cap_reg_write;
    c_wb_sel    = cap_wb_sel;
    c_funct3    = cap_funct3;
    c_alu       = cap_alu;
    c_pc        = cap_pc;
    if (state == ST_IDLE) begin
      commit      = accept && (in_wb_sel != WB_SEL_LOAD);
      c_rd        = in_rd;
      c_reg_write = in_reg_write;
      c_wb_sel    = in_wb_sel;
      c_funct3    = in_funct3;
      c_alu       = in_alu_result;
      c_pc        = in_pc_plus4;
    end else if (state == ST_WAIT_LOAD) begin
      commit = dmem_rvalid && !flush;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .addr   (c_alu[1:0]),
    .funct3 (c_funct3),
    .data   (la_data),
    .fault  (la_fault)
  );

  assign c_fault = (c_wb_sel == WB_SEL_LOAD) && la_fault;
  assign c_write = c_reg_write && (c_rd != '0) && !c_fault && (c_wb_sel != WB_SEL_RSVD);

  always_comb begin
    case (c_wb_sel)
      WB_SEL_LOAD: wb_data = la_data;
      WB_SEL_PC4:  wb_data = c_pc;
      default:     wb_data = c_alu;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
      misalign_err  <= 1'b0;
      cap_rd        <= '0;
      cap_reg_write <= 1'b0;
      cap_wb_sel    <= WB_SEL_ALU;
      cap_funct3    <= '0;
      cap_alu       <= '0;
      cap_pc        <= '0;
    end else begin
      RegWrite     <= 1'b0;
      misalign_err <= 1'b0;
      if (accept) begin
        cap_rd        <= in_rd;
        cap_reg_write <= in_reg_write;
        cap_wb_sel    <= in_wb_sel;
        cap_funct3    <= in_funct3;
        cap_alu       <= in_alu_result;
        cap_pc        <= in_pc_plus4;
      end
      if (commit) begin
        WriteRegister <= c_rd;
        RegWrite      <= c_write;
        misalign_err  <= c_fault;
        if (!c_fault && c_wb_sel != WB_SEL_RSVD) WriteData <= wb_data;
      end
    end
  end

endmodule
